// File: rtl/elev_pkg.sv
// Shared constants and types for the elevator request scheduler.
package elev_pkg;

    localparam logic [2:0] FL1_OH = 3'b001;
    localparam logic [2:0] FL2_OH = 3'b010;
    localparam logic [2:0] FL3_OH = 3'b100;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        SERVE    = 2'd2
    } state_t;

    function automatic logic [2:0] flr_onehot(input logic [1:0] flr);
        case (flr)
            2'd1:    return FL1_OH;
            2'd2:    return FL2_OH;
            2'd3:    return FL3_OH;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/elev_btn_cond.sv
// Call-button conditioning: optional 2-flop synchronizer (ELEV_BTN_SYNC_EN) then
// rising-edge detect, one lane per button.
module elev_btn_cond #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic [W-1:0] btn,
    output logic [W-1:0] rise
);

    logic [W-1:0] lvl;
    logic [W-1:0] lvl_prev;

`ifdef ELEV_BTN_SYNC_EN
    logic [W-1:0] btn_p0;
    logic [W-1:0] btn_p1;

    always_ff @(posedge clk) begin
        if (Reset) begin
            btn_p0 <= '0;
            btn_p1 <= '0;
        end else begin
            btn_p0 <= btn;
            btn_p1 <= btn_p0;
        end
    end

    assign lvl = btn_p1;
`else
    assign lvl = btn;
`endif

    always_ff @(posedge clk) begin
        if (Reset) lvl_prev <= '0;
        else       lvl_prev <= lvl;
    end

    assign rise = lvl & ~lvl_prev;

endmodule

// File: rtl/elev_req_sched.sv
// SCAN request scheduler for the 3-floor elevator controller. Build option:
// ELEV_BTN_SYNC_EN adds a 2-flop synchronizer on Btn.
module elev_req_sched
    import elev_pkg::*;
#(
    parameter int TMO_CYC = 64
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [3:1] Btn,
    input  logic       FLR1,
    input  logic       FLR2,
    input  logic       FLR3,
    input  logic       Door,
    output logic [3:1] Req,
    output logic [3:1] Pend,
    output logic       Dir,
    output logic       Tmo
);

    localparam int CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    state_t           state;
    logic [1:0]       cur;
    logic [1:0]       tgt;
    logic [CNT_W-1:0] cnt;
    logic [3:1]       rise;
    logic [3:1]       clr;
    logic [1:0]       up_flr;
    logic [1:0]       dn_flr;
    logic [1:0]       sel_flr;
    logic             sel_dir;
    logic             pend_cur;

    elev_btn_cond #(.W(3)) u_btn_cond (
        .clk   (clk),
        .Reset (Reset),
        .btn   (Btn),
        .rise  (rise)
    );

    assign clr = Door ? flr_onehot(cur) : 3'b000;

    // Nearest pending floor above/below cur; 0 means none in that direction.
    always_comb begin
        pend_cur = |(Pend & flr_onehot(cur));
        up_flr   = 2'd0;
        dn_flr   = 2'd0;
        case (cur)
            2'd1: up_flr = Pend[2] ? 2'd2 : (Pend[3] ? 2'd3 : 2'd0);
            2'd2: begin
                up_flr = Pend[3] ? 2'd3 : 2'd0;
                dn_flr = Pend[1] ? 2'd1 : 2'd0;
            end
            2'd3: dn_flr = Pend[2] ? 2'd2 : (Pend[1] ? 2'd1 : 2'd0);
            default: ;
        endcase

        sel_flr = cur;
        sel_dir = Dir;
        if (!pend_cur) begin
            if (Dir == DIR_UP && up_flr != 2'd0) begin
                sel_flr = up_flr;
            end else if (Dir == DIR_DN && dn_flr != 2'd0) begin
                sel_flr = dn_flr;
            end else if (Dir == DIR_UP) begin
                sel_flr = dn_flr;
                sel_dir = DIR_DN;
            end else begin
                sel_flr = up_flr;
                sel_dir = DIR_UP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && Pend != 3'b000) tgt <= sel_flr;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= IDLE;
            Req   <= 3'b000;
            Pend  <= 3'b000;
            Dir   <= DIR_UP;
            Tmo   <= 1'b0;
            cur   <= 2'd1;
            cnt   <= '0;
        end else begin
            // Clear beats a same-cycle set so an open door swallows a repeat press.
            Pend <= (Pend | rise) & ~clr;
            Tmo  <= 1'b0;

            case ({FLR3, FLR2, FLR1})
                3'b001:  cur <= 2'd1;
                3'b010:  cur <= 2'd2;
                3'b100:  cur <= 2'd3;
                default: ;
            endcase

            case (state)
                IDLE: begin
                    Req <= 3'b000;
                    if (Pend != 3'b000) begin
                        state <= DISPATCH;
                        Dir   <= sel_dir;
                        Req   <= flr_onehot(sel_flr);
                        cnt   <= '0;
                    end
                end
                DISPATCH: begin
                    if (Door && cur == tgt) begin
                        state <= SERVE;
                        Req   <= 3'b000;
                    end else if (cnt == CNT_W'(TMO_CYC - 1)) begin
                        Req <= 3'b000;
                        Tmo <= 1'b1;
                        cnt <= '0;
                    end else begin
                        Req <= flr_onehot(tgt);
                        cnt <= cnt + 1'b1;
                    end
                end
                SERVE: begin
                    Req <= 3'b000;
                    if (!Door) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    Req   <= 3'b000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elev_req_sched.sv
// Directed bench for elev_req_sched (default build, synchronizer compiled out).
module tb_elev_req_sched;

    logic       clk;
    logic       Reset;
    logic [3:1] Btn;
    logic       FLR1, FLR2, FLR3;
    logic       Door;
    logic [3:1] Req;
    logic [3:1] Pend;
    logic       Dir;
    logic       Tmo;

    int n_vec = 0;
    int n_err = 0;

    elev_req_sched #(.TMO_CYC(8)) dut (
        .clk   (clk),
        .Reset (Reset),
        .Btn   (Btn),
        .FLR1  (FLR1),
        .FLR2  (FLR2),
        .FLR3  (FLR3),
        .Door  (Door),
        .Req   (Req),
        .Pend  (Pend),
        .Dir   (Dir),
        .Tmo   (Tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic set_floor(input int f);
        FLR1 = (f == 1);
        FLR2 = (f == 2);
        FLR3 = (f == 3);
    endtask

    task automatic test_reset;
        Reset = 1'b1; tick(2);
        Reset = 1'b0; Btn = 3'b010; tick();
        n_vec++; if (Pend !== 3'b010) begin n_err++; $display("FAIL reset_prepend: got %b expected %b", Pend, 3'b010); end
        Btn = 3'b000; Reset = 1'b1; tick();
        Reset = 1'b0; tick();
        n_vec++; if (Req !== 3'b000) begin n_err++; $display("FAIL reset_req: got %b expected %b", Req, 3'b000); end
        n_vec++; if (Pend !== 3'b000) begin n_err++; $display("FAIL reset_pend: got %b expected %b", Pend, 3'b000); end
        n_vec++; if (Dir !== 1'b1) begin n_err++; $display("FAIL reset_dir: got %b expected %b", Dir, 1'b1); end
        n_vec++; if (Tmo !== 1'b0) begin n_err++; $display("FAIL reset_tmo: got %b expected %b", Tmo, 1'b0); end
    endtask

    task automatic test_single_call;
        Btn = 3'b100; tick();
        n_vec++; if (Pend !== 3'b100) begin n_err++; $display("FAIL single_pend: got %b expected %b", Pend, 3'b100); end
        n_vec++; if (Req !== 3'b000) begin n_err++; $display("FAIL single_req_idle: got %b expected %b", Req, 3'b000); end
        Btn = 3'b000; tick();
        n_vec++; if (Req !== 3'b100) begin n_err++; $display("FAIL single_req: got %b expected %b", Req, 3'b100); end
        set_floor(2); tick();
        set_floor(3); tick();
        n_vec++; if (Req !== 3'b100) begin n_err++; $display("FAIL single_req_hold: got %b expected %b", Req, 3'b100); end
        Door = 1'b1; tick();
        n_vec++; if (Req !== 3'b000) begin n_err++; $display("FAIL single_req_serve: got %b expected %b", Req, 3'b000); end
        n_vec++; if (Pend !== 3'b000) begin n_err++; $display("FAIL single_pend_clr: got %b expected %b", Pend, 3'b000); end
        Door = 1'b0; tick(2);
        n_vec++; if (Req !== 3'b000) begin n_err++; $display("FAIL single_idle_req: got %b expected %b", Req, 3'b000); end
    endtask

    task automatic test_scan;
        set_floor(2); tick();
        Btn = 3'b101; tick();
        n_vec++; if (Pend !== 3'b101) begin n_err++; $display("FAIL scan_pend: got %b expected %b", Pend, 3'b101); end
        Btn = 3'b000; tick();
        n_vec++; if (Req !== 3'b100) begin n_err++; $display("FAIL scan_first: got %b expected %b", Req, 3'b100); end
        n_vec++; if (Dir !== 1'b1) begin n_err++; $display("FAIL scan_dir_up: got %b expected %b", Dir, 1'b1); end
        set_floor(3); tick();
        Door = 1'b1; tick();
        n_vec++; if (Pend !== 3'b001) begin n_err++; $display("FAIL scan_pend_left: got %b expected %b", Pend, 3'b001); end
        Door = 1'b0; tick();
        n_vec++; if (Req !== 3'b000) begin n_err++; $display("FAIL scan_gap: got %b expected %b", Req, 3'b000); end
        tick();
        n_vec++; if (Req !== 3'b001) begin n_err++; $display("FAIL scan_second: got %b expected %b", Req, 3'b001); end
        n_vec++; if (Dir !== 1'b0) begin n_err++; $display("FAIL scan_dir_flip: got %b expected %b", Dir, 1'b0); end
        set_floor(1); tick();
        Door = 1'b1; tick();
        n_vec++; if (Pend !== 3'b000) begin n_err++; $display("FAIL scan_pend_done: got %b expected %b", Pend, 3'b000); end
        Door = 1'b0; tick(2);
    endtask

    task automatic test_same_floor;
        set_floor(2); tick();
        Btn = 3'b010; tick();
        Btn = 3'b000; tick();
        n_vec++; if (Req !== 3'b010) begin n_err++; $display("FAIL same_req: got %b expected %b", Req, 3'b010); end
        n_vec++; if (Dir !== 1'b0) begin n_err++; $display("FAIL same_dir: got %b expected %b", Dir, 1'b0); end
        Door = 1'b1; tick();
        n_vec++; if (Req !== 3'b000) begin n_err++; $display("FAIL same_serve: got %b expected %b", Req, 3'b000); end
        Btn = 3'b010; tick();
        n_vec++; if (Pend !== 3'b000) begin n_err++; $display("FAIL same_reopen: got %b expected %b", Pend, 3'b000); end
        Btn = 3'b000; Door = 1'b0; tick(2);
        n_vec++; if (Req !== 3'b000) begin n_err++; $display("FAIL same_idle: got %b expected %b", Req, 3'b000); end
    endtask

    task automatic test_timeout;
        Btn = 3'b001; tick();
        Btn = 3'b000; tick();
        n_vec++; if (Req !== 3'b001) begin n_err++; $display("FAIL tmo_req0: got %b expected %b", Req, 3'b001); end
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_vec++; if (Req !== 3'b001 || Tmo !== 1'b0) begin n_err++; $display("FAIL tmo_hold%0d: got req=%b tmo=%b expected req=001 tmo=0", i, Req, Tmo); end
        end
        tick();
        n_vec++; if (Req !== 3'b000 || Tmo !== 1'b1) begin n_err++; $display("FAIL tmo_pulse: got req=%b tmo=%b expected req=000 tmo=1", Req, Tmo); end
        tick();
        n_vec++; if (Req !== 3'b001 || Tmo !== 1'b0) begin n_err++; $display("FAIL tmo_reissue: got req=%b tmo=%b expected req=001 tmo=0", Req, Tmo); end
        set_floor(1); tick();
        Door = 1'b1; tick();
        n_vec++; if (Req !== 3'b000 || Pend !== 3'b000) begin n_err++; $display("FAIL tmo_serve: got req=%b pend=%b expected req=000 pend=000", Req, Pend); end
        Door = 1'b0; tick(2);
    endtask

    task automatic test_collision;
        Door = 1'b1; Btn = 3'b101; tick();
        n_vec++; if (Pend !== 3'b100) begin n_err++; $display("FAIL collide_pend: got %b expected %b", Pend, 3'b100); end
        Door = 1'b0; Btn = 3'b000; tick();
        n_vec++; if (Req !== 3'b100 || Dir !== 1'b1) begin n_err++; $display("FAIL collide_req: got req=%b dir=%b expected req=100 dir=1", Req, Dir); end
        Reset = 1'b1; tick();
        Reset = 1'b0;
        n_vec++; if (Req !== 3'b000 || Pend !== 3'b000) begin n_err++; $display("FAIL midreset: got req=%b pend=%b expected req=000 pend=000", Req, Pend); end
    endtask

    initial begin
        Reset = 1'b1;
        Btn   = 3'b000;
        Door  = 1'b0;
        set_floor(1);
        test_reset();
        test_single_call();
        test_scan();
        test_same_floor();
        test_timeout();
        test_collision();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
